// File: rtl/systolic_feed_scheduler_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | systolic_feed_scheduler_if                                               |
// | Control bundle between the feed scheduler, its row FIFOs and its host.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface systolic_feed_scheduler_if #(
    parameter int NUM_ROWS  = 4,
    parameter int LEN_WIDTH = 8
);
    logic                 start;
    logic [LEN_WIDTH-1:0] tile_len;
    logic [NUM_ROWS-1:0]  fifo_empty;
    logic [NUM_ROWS-1:0]  fifo_r_enable;
    logic [NUM_ROWS-1:0]  row_valid;
    logic                 busy;
    logic                 done;
    logic                 timeout_err;

    modport master (
        output start, tile_len, fifo_empty,
        input  fifo_r_enable, row_valid, busy, done, timeout_err
    );

    modport slave (
        input  start, tile_len, fifo_empty,
        output fifo_r_enable, row_valid, busy, done, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/systolic_feed_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | systolic_feed_scheduler                                                  |
// | Skewed, lock-step read sequencing of the west-edge row FIFOs.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module systolic_feed_scheduler #(
    parameter int NUM_ROWS      = 4,
    parameter int LEN_WIDTH     = 8,
    parameter int TIMEOUT_WIDTH = 4
) (
    input  wire logic                 clk,
    input  wire logic                 reset_n,
    systolic_feed_scheduler_if.slave  bus
);

    localparam int c_t_w = LEN_WIDTH + 1;
    localparam logic [TIMEOUT_WIDTH-1:0] c_stall_limit = {TIMEOUT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [c_t_w-1:0]         t_q, t_d;
    logic [LEN_WIDTH-1:0]     len_q, len_d;
    logic [TIMEOUT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic                     timeout_err_q, timeout_err_d;
    logic [NUM_ROWS-1:0]      row_valid_q, row_valid_d;

    logic [NUM_ROWS-1:0]      w_need;
    logic                     w_stall;
    logic [c_t_w-1:0]         w_last_t;
    logic [TIMEOUT_WIDTH-1:0] w_stall_inc;
    logic [NUM_ROWS-1:0]      w_r_enable;
    logic                     w_busy;
    logic                     w_done;

    // Row i is inside its window for steps i .. i+L-1.
    for (genvar i = 0; i < NUM_ROWS; i++) begin : g_need
        assign w_need[i] = (t_q >= c_t_w'(i)) &&
                           (t_q < ({1'b0, len_q} + c_t_w'(i)));
    end

    assign w_stall     = |(w_need & bus.fifo_empty);
    assign w_last_t    = {1'b0, len_q} + c_t_w'(NUM_ROWS - 2);
    assign w_stall_inc = stall_cnt_q + TIMEOUT_WIDTH'(1);

    always_comb begin
        state_d       = state_q;
        t_d           = t_q;
        len_d         = len_q;
        stall_cnt_d   = stall_cnt_q;
        timeout_err_d = timeout_err_q;
        w_r_enable    = '0;
        w_busy        = 1'b0;
        w_done        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    len_d         = bus.tile_len;
                    t_d           = '0;
                    stall_cnt_d   = '0;
                    timeout_err_d = 1'b0;
                    state_d       = (bus.tile_len == '0) ? S_FLUSH : S_FEED;
                end
            end
            S_FEED: begin
                w_busy = 1'b1;
                if (w_stall) begin
                    // The aborting cycle is itself a stall, so it never reads.
                    if (w_stall_inc == c_stall_limit) begin
                        state_d       = S_IDLE;
                        timeout_err_d = 1'b1;
                        stall_cnt_d   = '0;
                    end else begin
                        stall_cnt_d = w_stall_inc;
                    end
                end else begin
                    w_r_enable  = w_need;
                    stall_cnt_d = '0;
                    t_d         = t_q + c_t_w'(1);
                    if (t_q == w_last_t) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                w_busy  = 1'b1;
                w_done  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign row_valid_d = w_r_enable;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            t_q           <= '0;
            len_q         <= '0;
            stall_cnt_q   <= '0;
            timeout_err_q <= 1'b0;
            row_valid_q   <= '0;
        end else begin
            state_q       <= state_d;
            t_q           <= t_d;
            len_q         <= len_d;
            stall_cnt_q   <= stall_cnt_d;
            timeout_err_q <= timeout_err_d;
            row_valid_q   <= row_valid_d;
        end
    end

    assign bus.fifo_r_enable = w_r_enable;
    assign bus.row_valid     = row_valid_q;
    assign bus.busy          = w_busy;
    assign bus.done          = w_done;
    assign bus.timeout_err   = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_systolic_feed_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_systolic_feed_scheduler                                               |
// | Directed stimulus against a step-count model of the feed schedule.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_systolic_feed_scheduler;

    localparam int NR = 4;
    localparam int LW = 8;
    localparam int TW = 4;

    logic clk;
    logic reset_n;

    systolic_feed_scheduler_if #(.NUM_ROWS(NR), .LEN_WIDTH(LW)) bus ();

    systolic_feed_scheduler #(
        .NUM_ROWS      (NR),
        .LEN_WIDTH     (LW),
        .TIMEOUT_WIDTH (TW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mode 0=idle 1=feed 2=flush; prog counts completed (non-stalled) feed steps.
    int         m_mode, m_prog, m_run, m_len;
    bit         m_terr;
    logic [3:0] m_rv;

    function automatic logic [3:0] want(input int prog, input int len);
        logic [3:0] w;
        for (int i = 0; i < NR; i++) w[i] = (prog >= i) && (prog < i + len);
        return w;
    endfunction

    function automatic logic [3:0] model_ren();
        logic [3:0] w;
        w = want(m_prog, m_len);
        if (m_mode == 1 && (w & bus.fifo_empty) == 4'b0) return w;
        return 4'b0;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_mode <= 0; m_prog <= 0; m_run <= 0; m_len <= 0;
            m_terr <= 1'b0; m_rv <= 4'b0;
        end else begin
            m_rv <= model_ren();
            case (m_mode)
                0: if (bus.start) begin
                    m_terr <= 1'b0;
                    m_len  <= int'(bus.tile_len);
                    m_prog <= 0;
                    m_run  <= 0;
                    m_mode <= (bus.tile_len == 0) ? 2 : 1;
                end
                1: if ((want(m_prog, m_len) & bus.fifo_empty) != 4'b0) begin
                    if (m_run + 1 == (1 << TW) - 1) begin
                        m_mode <= 0;
                        m_terr <= 1'b1;
                    end else m_run <= m_run + 1;
                end else begin
                    m_run  <= 0;
                    m_prog <= m_prog + 1;
                    // A tile needs L+N-1 read steps in total.
                    if (m_prog + 1 == m_len + NR - 1) m_mode <= 2;
                end
                default: m_mode <= 0;
            endcase
        end
    end

    int rd_cnt[NR];

    always @(negedge clk) begin
        if (reset_n) begin
            chk("r_enable", int'(bus.fifo_r_enable), int'(model_ren()));
            chk("row_valid", int'(bus.row_valid), int'(m_rv));
            chk("busy", int'(bus.busy), int'(m_mode != 0));
            chk("done", int'(bus.done), int'(m_mode == 2));
            chk("timeout_err", int'(bus.timeout_err), int'(m_terr));
            chk("read_while_empty", int'(bus.fifo_r_enable & bus.fifo_empty), 0);
            if (m_mode == 0) begin
                for (int i = 0; i < NR; i++) rd_cnt[i] = 0;
            end else begin
                for (int i = 0; i < NR; i++) rd_cnt[i] += int'(bus.fifo_r_enable[i]);
            end
            if (bus.done) begin
                for (int i = 0; i < NR; i++) chk($sformatf("row%0d_reads", i), rd_cnt[i], m_len);
            end
        end
    end

    logic [3:0] ren_log  [0:31];
    logic [3:0] rv_log   [0:31];
    logic       done_log [0:31];
    logic       busy_log [0:31];
    logic       terr_log [0:31];

    function automatic logic [3:0] empty_for(input int mode, input int k);
        if (mode == 1) return (k >= 3 && k <= 5) ? 4'b0100 : 4'b0000;
        if (mode == 2) return 4'b0001;
        return 4'b0000;
    endfunction

    // Starts a tile on edge 0 and logs cycles 1..ncyc.
    task automatic run_tile(input int len, input int mode, input int ncyc, input int s_cyc);
        bus.start    = 1'b1;
        bus.tile_len = LW'(len);
        @(posedge clk); #1;
        for (int k = 1; k <= ncyc; k++) begin
            bus.fifo_empty = empty_for(mode, k);
            bus.start      = (k == s_cyc);
            @(negedge clk);
            ren_log[k]  = bus.fifo_r_enable;
            rv_log[k]   = bus.row_valid;
            done_log[k] = bus.done;
            busy_log[k] = bus.busy;
            terr_log[k] = bus.timeout_err;
            @(posedge clk); #1;
        end
        bus.start      = 1'b0;
        bus.fifo_empty = 4'b0;
    endtask

    logic [3:0] nom_ren [1:8] = '{4'h1, 4'h3, 4'h7, 4'hE, 4'hC, 4'h8, 4'h0, 4'h0};
    logic [3:0] stl_ren [1:10] = '{4'h1, 4'h3, 4'h0, 4'h0, 4'h0, 4'h7, 4'hE, 4'hC, 4'h8, 4'h0};

    task automatic check_nominal(input string tag);
        for (int k = 1; k <= 8; k++) begin
            chk({tag, "_ren"}, int'(ren_log[k]), int'(nom_ren[k]));
            chk({tag, "_done"}, int'(done_log[k]), int'(k == 7));
            if (k >= 2) chk({tag, "_rv"}, int'(rv_log[k]), int'(nom_ren[k-1]));
        end
    endtask

    int total;
    int ndone;

    initial begin
        reset_n        = 1'b0;
        bus.start      = 1'b0;
        bus.tile_len   = '0;
        bus.fifo_empty = '0;
        #1;
        chk("reset_ren", int'(bus.fifo_r_enable), 0);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_terr", int'(bus.timeout_err), 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;

        // Nominal L=3
        run_tile(3, 0, 9, 0);
        check_nominal("nominal");

        // Row 2 empty during cycles 3..5
        run_tile(3, 1, 11, 0);
        for (int k = 1; k <= 10; k++) begin
            chk("stall_ren", int'(ren_log[k]), int'(stl_ren[k]));
            chk("stall_done", int'(done_log[k]), int'(k == 10));
        end

        // Row 0 never ready: watchdog abort
        run_tile(3, 2, 18, 0);
        chk("to_busy15", int'(busy_log[15]), 1);
        chk("to_busy16", int'(busy_log[16]), 0);
        chk("to_terr15", int'(terr_log[15]), 0);
        chk("to_terr16", int'(terr_log[16]), 1);
        ndone = 0;
        for (int k = 1; k <= 18; k++) ndone += int'(done_log[k]);
        chk("to_no_done", ndone, 0);

        // Zero-length tile; also clears the sticky error
        run_tile(0, 0, 3, 0);
        chk("zero_done1", int'(done_log[1]), 1);
        chk("zero_busy1", int'(busy_log[1]), 1);
        chk("zero_busy2", int'(busy_log[2]), 0);
        chk("zero_terr1", int'(terr_log[1]), 0);
        chk("zero_ren1", int'(ren_log[1]), 0);

        // Start during FEED, then start in the done cycle
        for (int s = 0; s < 2; s++) begin
            run_tile(3, 0, 10, (s == 0) ? 3 : 7);
            total = 0;
            ndone = 0;
            for (int k = 1; k <= 10; k++) begin
                total += $countones(ren_log[k]);
                ndone += int'(done_log[k]);
            end
            chk("ignored_start_reads", total, 12);
            chk("ignored_start_dones", ndone, 1);
            chk("ignored_start_busy8", int'(busy_log[8]), 0);
        end

        // Async reset in cycle 4
        bus.start    = 1'b1;
        bus.tile_len = 8'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        reset_n = 1'b0;
        #1;
        chk("arst_ren", int'(bus.fifo_r_enable), 0);
        chk("arst_rv", int'(bus.row_valid), 0);
        chk("arst_busy", int'(bus.busy), 0);
        chk("arst_done", int'(bus.done), 0);
        chk("arst_terr", int'(bus.timeout_err), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        run_tile(3, 0, 9, 0);
        check_nominal("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
